fc_score_accumulator: RTL and testbench

//  Final fully-connected layer feeding max_finder. Streams N_FEATURES activations, one per handshake beat.

---
 rtl/fc_score_accumulator_pkg.sv | 19 +
 rtl/fc_score_accumulator_if.sv | 28 ++
 rtl/fc_score_accumulator_mac_lane.sv | 51 +++++
 rtl/fc_score_accumulator.sv | 99 +++++++++
 tb/tb_fc_score_accumulator.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fc_score_accumulator_pkg.sv
// Shared types and helpers for the fully-connected score accumulator.
// Package fc_pkg: FSM state encoding, default sizes, offset-binary conversion.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned ACC_W_DEF       = 32;

  // Invert bit (w-1) so an unsigned compare of the low w bits orders signed values.
  function automatic logic [63:0] to_offset(input logic [63:0] v, input int unsigned w);
    return v ^ (64'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/fc_score_accumulator_if.sv
// Feature stream / score handshake bundle for fc_score_accumulator.
// master = producer of features and consumer of scores; slave = the accumulator.
interface fc_score_accumulator_if #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned W_W         = 8,
  parameter int unsigned ACC_W       = 32
);
  logic                         start;
  logic                         feat_valid;
  logic                         feat_ready;
  logic [DATA_W-1:0]            feat_data;
  logic [NUM_CLASSES*W_W-1:0]   w_data;
  logic                         scores_valid;
  logic                         scores_ack;
  logic [NUM_CLASSES*ACC_W-1:0] scores;
  logic                         busy;

  modport master (
    output start, feat_valid, feat_data, w_data, scores_ack,
    input  feat_ready, scores_valid, scores, busy
  );

  modport slave (
    input  start, feat_valid, feat_data, w_data, scores_ack,
    output feat_ready, scores_valid, scores, busy
  );
endinterface

// File: rtl/fc_score_accumulator_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane with clear and enable.
// Optional feature: define SCORE_SAT_EN for saturating accumulation,
// otherwise the accumulator wraps modulo 2^ACC_W.
// acc_nxt exposes the value the accumulator takes on the coming edge so the
// top can capture the final score on the same edge as the last add.
module fc_mac_lane #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned W_W    = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [W_W-1:0]    w,
  output logic [ACC_W-1:0]         acc_nxt
);
  logic [ACC_W-1:0]                acc_q, acc_d;
  logic signed [DATA_W+W_W-1:0]    prod;
  logic signed [ACC_W-1:0]         prod_ext;

  // Next accumulator value: clear, or add the sign-extended product.
  always_comb begin
    prod     = a * w;
    prod_ext = ACC_W'(prod);
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
`ifdef SCORE_SAT_EN
      logic [ACC_W:0] sum;
      sum = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
      if (sum[ACC_W] != sum[ACC_W-1])
        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_d = sum[ACC_W-1:0];
`else
      acc_d = acc_q + prod_ext;
`endif
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_nxt = acc_d;
endmodule

// File: rtl/fc_score_accumulator.sv
// fc_score_accumulator: final FC layer; NUM_CLASSES parallel signed MAC lanes
// over N_FEATURES beats, scores presented in offset-binary for max_finder.
// Optional feature macro: SCORE_SAT_EN (saturating lanes, see fc_mac_lane).
module fc_score_accumulator
  import fc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned N_FEATURES  = 64,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned W_W         = 8,
  parameter int unsigned ACC_W       = ACC_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  fc_score_accumulator_if.slave bus
);
  localparam int unsigned CNT_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_CLASSES*ACC_W-1:0] scores_q, scores_d;
  logic [NUM_CLASSES*ACC_W-1:0] acc_nxt;
  logic                         clr, en;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    fc_mac_lane #(
      .DATA_W (DATA_W),
      .W_W    (W_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .a       (bus.feat_data),
      .w       (bus.w_data[k*W_W +: W_W]),
      .acc_nxt (acc_nxt[k*ACC_W +: ACC_W])
    );
  end

  // FSM next state, beat counter, lane control and score capture on DONE entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scores_d = scores_q;
    clr      = 1'b0;
    en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        if (bus.feat_valid) begin
          en    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_FEATURES - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            // Capture from the lanes' next values so the final beat is included.
            for (int unsigned k = 0; k < NUM_CLASSES; k++)
              scores_d[k*ACC_W +: ACC_W] = ACC_W'(to_offset(64'(acc_nxt[k*ACC_W +: ACC_W]), ACC_W));
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          clr     = 1'b1;
        end else if (bus.scores_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and score registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scores_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scores_q <= scores_d;
    end
  end

  assign bus.feat_ready   = (state_q == ACCUM);
  assign bus.busy         = (state_q == ACCUM);
  assign bus.scores_valid = (state_q == DONE);
  assign bus.scores       = scores_q;
endmodule

// File: tb/tb_fc_score_accumulator.sv
// Scoreboard bench for fc_score_accumulator: stimulus pushes expected scores,
// monitors pop and compare when scores_valid rises.
module tb_fc_score_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  fc_score_accumulator_if #(.NUM_CLASSES(10), .DATA_W(8), .W_W(8), .ACC_W(32)) if0 ();
  fc_score_accumulator_if #(.NUM_CLASSES(2),  .DATA_W(8), .W_W(8), .ACC_W(16)) if1 ();

  fc_score_accumulator #(.NUM_CLASSES(10), .N_FEATURES(64), .DATA_W(8), .W_W(8), .ACC_W(32))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  fc_score_accumulator #(.NUM_CLASSES(2), .N_FEATURES(3), .DATA_W(8), .W_W(8), .ACC_W(16))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [319:0] exp0_q[$];
  logic [31:0]  exp1_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, req);
  endtask

  function automatic logic [319:0] exp_vec(input logic [31:0] s3, input logic [31:0] so);
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = (k == 3) ? s3 : so;
    return v;
  endfunction

  // Monitor for the 10-class instance.
  logic prev0 = 1'b0;
  always @(negedge clk) begin
    if (!rst && if0.scores_valid && !prev0) begin
      if (exp0_q.size() == 0) begin
        check("unexpected_scores0", 64'd1, 64'd0);
      end else begin
        logic [319:0] e;
        e = exp0_q.pop_front();
        for (int k = 0; k < 10; k++)
          check($sformatf("score0_%0d", k), 64'(if0.scores[k*32 +: 32]), 64'(e[k*32 +: 32]));
      end
    end
    prev0 = if0.scores_valid;
  end

  // Monitor for the 16-bit instance.
  logic prev1 = 1'b0;
  always @(negedge clk) begin
    if (!rst && if1.scores_valid && !prev1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_scores1", 64'd1, 64'd0);
      end else begin
        logic [31:0] e;
        e = exp1_q.pop_front();
        for (int k = 0; k < 2; k++)
          check($sformatf("score1_%0d", k), 64'(if1.scores[k*16 +: 16]), 64'(e[k*16 +: 16]));
      end
    end
    prev1 = if1.scores_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One frame on dut0: start, 64 beats (optional one-cycle gap after each).
  task automatic run_frame(input logic [7:0] f, input logic [7:0] w3, input logic [7:0] wo,
                           input bit gaps, input logic [319:0] exp);
    exp0_q.push_back(exp);
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    check("busy_after_start", 64'(if0.busy), 64'd1);
    check("valid_low_after_start", 64'(if0.scores_valid), 64'd0);
    for (int i = 0; i < 64; i++) begin
      if0.feat_valid = 1'b1;
      if0.feat_data  = f;
      for (int k = 0; k < 10; k++) if0.w_data[k*8 +: 8] = (k == 3) ? w3 : wo;
      if (i == 63) check("valid_low_before_last", 64'(if0.scores_valid), 64'd0);
      tick();
      if0.feat_valid = 1'b0;
      if (gaps && i != 63) begin
        if0.feat_data = 8'($urandom);
        if0.w_data    = {$urandom, $urandom, 16'($urandom)};
        tick();
        check("valid_low_in_gap", 64'(if0.scores_valid), 64'd0);
      end
    end
    check("valid_after_last", 64'(if0.scores_valid), 64'd1);
    check("ready_low_done", 64'(if0.feat_ready), 64'd0);
  endtask

  task automatic ack0();
    if0.scores_ack = 1'b1;
    tick();
    if0.scores_ack = 1'b0;
    check("idle_after_ack", 64'(if0.scores_valid), 64'd0);
  endtask

  initial begin
    logic [319:0] e2;
    e2 = exp_vec(32'h8000_0080, 32'h8000_0040);
    if0.start = 0; if0.feat_valid = 0; if0.feat_data = '0; if0.w_data = '0; if0.scores_ack = 0;
    if1.start = 0; if1.feat_valid = 0; if1.feat_data = '0; if1.w_data = '0; if1.scores_ack = 0;

    // 1: reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_ready", 64'(if0.feat_ready), 64'd0);
    check("rst_valid", 64'(if0.scores_valid), 64'd0);
    check("rst_busy", 64'(if0.busy), 64'd0);
    check("rst_scores0", 64'(if0.scores[63:0]), 64'd0);
    check("rst_scores1", 64'(if1.scores), 64'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_no_start_busy", 64'(if0.busy), 64'd0);
    check("idle_no_start_ready", 64'(if0.feat_ready), 64'd0);

    // 2: basic frame
    run_frame(8'd1, 8'd2, 8'd1, 1'b0, e2);
    ack0();
    check("hold_after_ack", 64'(if0.scores[127:96]), 64'h8000_0080);

    // 3: negative feature
    run_frame(8'hFF, 8'd1, 8'd1, 1'b0, exp_vec(32'h7FFF_FFC0, 32'h7FFF_FFC0));
    ack0();

    // 4: gapped feature stream
    run_frame(8'd1, 8'd2, 8'd1, 1'b1, e2);

    // 5: restart from DONE without ack; accumulators must start from zero
    run_frame(8'd1, 8'd2, 8'd1, 1'b0, e2);
    ack0();

    // 6: reset mid-frame, then fresh frame
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if0.feat_valid = 1'b1; if0.feat_data = 8'd5;
      for (int k = 0; k < 10; k++) if0.w_data[k*8 +: 8] = 8'd3;
      tick();
    end
    if0.feat_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 64'(if0.busy), 64'd0);
    check("midrst_valid", 64'(if0.scores_valid), 64'd0);
    check("midrst_scores", 64'(if0.scores[63:0]), 64'd0);
    tick();
    run_frame(8'd1, 8'd2, 8'd1, 1'b0, e2);
    ack0();

    // 7: 16-bit accumulator, 3 beats of 127*127
`ifdef SCORE_SAT_EN
    exp1_q.push_back({16'hFFFF, 16'hFFFF});
`else
    exp1_q.push_back({16'h3D03, 16'h3D03});
`endif
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if1.feat_valid = 1'b1; if1.feat_data = 8'd127; if1.w_data = {8'd127, 8'd127};
      tick();
    end
    if1.feat_valid = 1'b0;
    check("w16_valid", 64'(if1.scores_valid), 64'd1);
    tick(); tick();

    check("scoreboard_drained", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
